matrix_stream_transposer: RTL and testbench
===========================================

// Module: matrix_stream_transposer
// PURPOSE
//  Streaming counterpart of the combinational transpose: accepts an MxN matrix one element per
//  handshake in row-major order, buffers it, then emits it element-serially in column-major
//  order (i.e. the NxM transpose, row-major). Sits between serial matrix sources (loaders,
//  MAC pipelines) and the pseudoinverse datapath; also exposes the full transposed flat bus.
// PARAMETERS
//  M      2  rows of the input matrix (>=1)
//  N      2  columns of the input matrix (>=1)
//  nBits  2  bits per element (>=1)
// PORTS
//  clk        in   1           rising-edge clock, single clock domain
//  rst_n      in   1           asynchronous active-low reset
//  flush      in   1           sync abort: discard matrix, return to FILL
//  in_valid   in   1           input element valid
//  in_ready   out  1           block accepts input element
//  in_data    in   nBits       input element, row-major order
//  out_valid  out  1           output element valid
//  out_ready  in   1           downstream accepts output element
//  out_data   out  nBits       output element, column-major order of input
//  out_last   out  1           high with final (M*N-th) output element
//  mat_valid  out  1           b_flat holds complete transposed matrix (high throughout DRAIN)
//  b_flat     out  N*M*nBits   transposed NxM matrix; element (i,j) at [M*N*nBits-(M*i+j)*nBits-1 -: nBits]
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=FILL, row/col counters=0, storage=0, in_ready=0,
//    out_valid=0, out_last=0, mat_valid=0, out_data=0, b_flat=0.
//  - in_ready is registered: 1 from first clk edge after rst_n release while in FILL.
//  - FILL: element accepted when in_valid&&in_ready; written at (r,c); c increments, wraps N-1->0
//    with r+1. Accepting element (M-1,N-1): next edge state=DRAIN, in_ready=0, out_valid=1,
//    mat_valid=1, counters=0. Latency last-in accept -> first out_valid: 1 cycle.
//  - DRAIN: out_data = A[r][c] for output index k: r=k%M, c=k/M (r increments fastest, wraps M-1->0
//    with c+1). Advance only on out_valid&&out_ready; out_data/out_last stable while out_ready=0.
//    out_last=1 exactly when k=M*N-1. Last handshake: next edge state=FILL, out_valid=0,
//    mat_valid=0, in_ready=1. in_valid ignored in DRAIN. No fill/drain overlap.
//  - Throughput: M*N in-cycles + M*N out-cycles per matrix minimum; no bubbles within a phase.
//  - flush=1 (either state, priority over handshakes): next edge state=FILL, counters=0,
//    out_valid/out_last/mat_valid=0, in_ready=1; storage unchanged; any handshake that cycle lost.
//  - rst_n asserted mid-operation: immediate return to reset values; partial matrix discarded.
//  - Degenerate sizes: M=1 or N=1 valid (order equals input order); M*N=1: DRAIN lasts one
//    handshake with out_last=1.
//  - Counter widths: max($clog2(M),1) and max($clog2(N),1); no overflow past M-1/N-1.
//  - b_flat: transpose of stored row-major matrix; meaningful only when mat_valid=1.
// STRUCTURE
//  - Shared header matrix_defs.vh: CLOG2-with-min-1 macro, row-major flat-index macro
//    IDX(i,j,cols,nBits) for MSB-first packing used by all matrix blocks.
//  - Storage kept as one M*N*nBits row-major flat register; b_flat produced by instantiating
//    the existing combinational transpose module (M, N, nBits) on it.
//  - Sub-module: none new; FSM (FILL/DRAIN), counters and output mux in this module.
// TESTING
//  1 M=2,N=3,nBits=8: inputs 1..6 back-to-back -> outputs 1,4,2,5,3,6; out_last on 6;
//    first out_valid 1 cycle after 6 accepted; b_flat={8'd1,8'd4,8'd2,8'd5,8'd3,8'd6}.
//  2 Same, random in_valid gaps and out_ready stalls -> identical order; out_data stable while
//    stalled; in_ready=0 and in_valid ignored throughout DRAIN.
//  3 Two matrices 1..6 then 11..16 -> 1,4,2,5,3,6 then 11,14,12,15,13,16; in_ready=1 the
//    cycle after first out_last handshake.
//  4 flush after 3 inputs, then 6 new inputs 21..26 -> outputs 21,24,22,25,23,26; flush mid-DRAIN
//    after 2 outputs -> out_valid=0 next cycle, FILL resumes.
//  5 rst_n pulse mid-DRAIN -> all outputs at reset values immediately; in_ready=1 after release.
//  6 M=1,N=1: input 8'hA5 -> single output 8'hA5 with out_last=1; M=3,N=1: 7,8,9 -> 7,8,9.

Source files
------------

// File: rtl/matrix_stream_transposer_pkg.sv
// Shared types and index helpers for the matrix streaming blocks.
package matrix_stream_transposer_pkg;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Ceiling log2 that never returns less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  // MSB bit position of element (i,j) in an MSB-first row-major flat bus.
  function automatic int flat_msb(input int i, input int j, input int rows,
                                  input int cols, input int nbits);
    return rows * cols * nbits - (i * cols + j) * nbits - 1;
  endfunction

endpackage

// File: rtl/matrix_stream_transposer_transpose.sv
// Combinational transpose of an MxN row-major flat matrix into its NxM
// transpose, same packing convention.
module matrix_stream_transposer_transpose
  import matrix_stream_transposer_pkg::*;
#(
  parameter int M     = 2,
  parameter int N     = 2,
  parameter int nBits = 2
) (
  input  logic [M*N*nBits-1:0] a_flat,
  output logic [M*N*nBits-1:0] b_flat
);

  // B(i,j) = A(j,i); pure wiring.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < M; j++) begin : g_col
      assign b_flat[flat_msb(i, j, N, M, nBits) -: nBits] =
             a_flat[flat_msb(j, i, M, N, nBits) -: nBits];
    end
  end

endmodule

// File: rtl/matrix_stream_transposer.sv
// Streaming matrix transposer: fills an MxN matrix in row-major order, then
// drains it element-serially in column-major order. The full transpose is
// also exposed as a flat bus while draining.
module matrix_stream_transposer
  import matrix_stream_transposer_pkg::*;
#(
  parameter int M     = 2,
  parameter int N     = 2,
  parameter int nBits = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [nBits-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [nBits-1:0]       out_data,
  output logic                   out_last,
  output logic                   mat_valid,
  output logic [M*N*nBits-1:0]   b_flat
);

  localparam int RW    = clog2_min1(M);
  localparam int CW    = clog2_min1(N);
  localparam int KW    = clog2_min1(M * N);
  localparam int KSIZE = 1 << KW;
  localparam int FW    = M * N * nBits;

  localparam logic [RW-1:0] R_MAX  = RW'(M - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [RW-1:0] R_ZERO = {RW{1'b0}};
  localparam logic [CW-1:0] C_MAX  = CW'(N - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
  localparam logic          SINGLE = (M * N == 1) ? 1'b1 : 1'b0;

  state_t             state_r;
  logic [RW-1:0]      row_r;
  logic [CW-1:0]      col_r;
  logic [FW-1:0]      store_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               out_last_r;
  logic               mat_valid_r;
  logic [nBits-1:0]   out_data_r;

  logic               in_fire_s;
  logic               out_fire_s;
  logic               at_end_s;
  logic [RW-1:0]      fill_row_nxt_s;
  logic [CW-1:0]      fill_col_nxt_s;
  logic [RW-1:0]      drain_row_nxt_s;
  logic [CW-1:0]      drain_col_nxt_s;
  logic               drain_last_nxt_s;
  logic [KW-1:0]      wr_idx_s;
  logic [KW-1:0]      rd_idx_s;
  logic [FW-1:0]      store_nxt_s;
  logic [nBits-1:0]   next_elem_s;
  logic [nBits-1:0]   first_elem_s;
  logic [nBits-1:0]   mem_s [0:KSIZE-1];

  // Handshakes, counter stepping and element addressing.
  always_comb begin
    in_fire_s        = (state_r == ST_FILL) && in_valid && in_ready_r;
    out_fire_s       = (state_r == ST_DRAIN) && out_valid_r && out_ready;
    at_end_s         = (row_r == R_MAX) && (col_r == C_MAX);
    // Fill walks columns fastest (row-major).
    fill_col_nxt_s   = (col_r == C_MAX) ? C_ZERO : col_r + C_ONE;
    fill_row_nxt_s   = (col_r == C_MAX) ? ((row_r == R_MAX) ? R_ZERO : row_r + R_ONE) : row_r;
    // Drain walks rows fastest (column-major).
    drain_row_nxt_s  = (row_r == R_MAX) ? R_ZERO : row_r + R_ONE;
    drain_col_nxt_s  = (row_r == R_MAX) ? ((col_r == C_MAX) ? C_ZERO : col_r + C_ONE) : col_r;
    drain_last_nxt_s = (drain_row_nxt_s == R_MAX) && (drain_col_nxt_s == C_MAX);
    wr_idx_s         = KW'(row_r) * KW'(N) + KW'(col_r);
    rd_idx_s         = KW'(drain_row_nxt_s) * KW'(N) + KW'(drain_col_nxt_s);
    next_elem_s      = mem_s[rd_idx_s];
    first_elem_s     = store_nxt_s[FW-1 -: nBits];
  end

  // Per-element write-back and a padded array view of the stored matrix.
  for (genvar e = 0; e < KSIZE; e++) begin : g_elem
    if (e < M * N) begin : g_real
      assign store_nxt_s[FW - e*nBits - 1 -: nBits] =
             (in_fire_s && (wr_idx_s == KW'(e))) ? in_data : store_r[FW - e*nBits - 1 -: nBits];
      assign mem_s[e] = store_r[FW - e*nBits - 1 -: nBits];
    end else begin : g_pad
      assign mem_s[e] = {nBits{1'b0}};
    end
  end

  // FILL/DRAIN sequencer with registered handshake and data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_FILL;
      row_r       <= R_ZERO;
      col_r       <= C_ZERO;
      store_r     <= {FW{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      mat_valid_r <= 1'b0;
      out_data_r  <= {nBits{1'b0}};
    end else if (flush) begin
      // Abort: storage is kept, everything else returns to an empty FILL.
      state_r     <= ST_FILL;
      row_r       <= R_ZERO;
      col_r       <= C_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      mat_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FILL: begin
          store_r <= store_nxt_s;
          if (in_fire_s && at_end_s) begin
            state_r     <= ST_DRAIN;
            row_r       <= R_ZERO;
            col_r       <= C_ZERO;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
            mat_valid_r <= 1'b1;
            out_data_r  <= first_elem_s;
            out_last_r  <= SINGLE;
          end else if (in_fire_s) begin
            row_r      <= fill_row_nxt_s;
            col_r      <= fill_col_nxt_s;
            in_ready_r <= 1'b1;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_fire_s && at_end_s) begin
            state_r     <= ST_FILL;
            row_r       <= R_ZERO;
            col_r       <= C_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            mat_valid_r <= 1'b0;
          end else if (out_fire_s) begin
            row_r      <= drain_row_nxt_s;
            col_r      <= drain_col_nxt_s;
            out_data_r <= next_elem_s;
            out_last_r <= drain_last_nxt_s;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_FILL;
          row_r       <= R_ZERO;
          col_r       <= C_ZERO;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          mat_valid_r <= 1'b0;
        end
      endcase
    end
  end

  matrix_stream_transposer_transpose #(
    .M     (M),
    .N     (N),
    .nBits (nBits)
  ) u_transpose (
    .a_flat (store_r),
    .b_flat (b_flat)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign mat_valid = mat_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_matrix_stream_transposer.sv
// Scoreboard bench for matrix_stream_transposer: a 2x3x8 main instance plus
// 1x1 and 3x1 instances for the degenerate shapes.
module tb_matrix_stream_transposer;

  localparam int M = 2;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, out_last, mat_valid;
  logic [7:0]  out_data;
  logic [47:0] b_flat;

  logic        flush_a, in_valid_a, out_ready_a;
  logic [7:0]  in_data_a;
  logic        in_ready_a, out_valid_a, out_last_a, mat_valid_a;
  logic [7:0]  out_data_a;
  logic [7:0]  b_flat_a;

  logic        flush_b, in_valid_b, out_ready_b;
  logic [7:0]  in_data_b;
  logic        in_ready_b, out_valid_b, out_last_b, mat_valid_b;
  logic [7:0]  out_data_b;
  logic [23:0] b_flat_b;

  int checks   = 0;
  int failures = 0;
  logic [8:0] sb_q[$];
  logic [8:0] sb_b[$];

  matrix_stream_transposer #(.M(M), .N(N), .nBits(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .mat_valid(mat_valid), .b_flat(b_flat));

  matrix_stream_transposer #(.M(1), .N(1), .nBits(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_last(out_last_a), .mat_valid(mat_valid_a), .b_flat(b_flat_a));

  matrix_stream_transposer #(.M(3), .N(1), .nBits(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_last(out_last_b), .mat_valid(mat_valid_b), .b_flat(b_flat_b));

  // Load base..base+5 row-major, push the column-major expectation.
  task automatic fill_main(input logic [7:0] base, input int gap_pct);
    int acc = 0;
    int cyc = 0;
    for (int k = 0; k < M*N; k++) begin
      int r = k % M;
      int c = k / M;
      sb_q.push_back({(k == M*N-1) ? 1'b1 : 1'b0, 8'(int'(base) + r*N + c)});
    end
    while (acc < M*N && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = 8'(int'(base) + acc);
        if (in_ready) acc++;
      end
    end
    checks++;
    if (acc != M*N) begin
      failures++;
      $display("FAIL fill_timeout: accepted %0d required %0d", acc, M*N);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, mat_valid, in_ready} !== 3'b110) begin
      failures++;
      $display("FAIL drain_entry: got valid/mat/ready=%b required 110", {out_valid, mat_valid, in_ready});
    end
  endtask

  // Pop and compare up to max_out outputs with random stalls.
  task automatic drain_main(input int stall_pct, input int max_out);
    int got = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    while (got < max_out && sb_q.size() > 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'($urandom_range(1));
      in_data  = 8'($urandom_range(255));
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL drain_in_ready: got %b required 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL drain_out_valid: got %b required 1", out_valid);
        out_ready = 1'b0;
        break;
      end
      if (prev_stall) begin
        checks++;
        if (out_data !== prev_data) begin
          failures++;
          $display("FAIL stall_stable: got %0h required %0h", out_data, prev_data);
        end
      end
      checks++;
      if ({out_last, out_data} !== sb_q[0]) begin
        failures++;
        $display("FAIL drain_data: got last=%b data=%0h required last=%b data=%0h",
                 out_last, out_data, sb_q[0][8], sb_q[0][7:0]);
      end
      out_ready = ($urandom_range(99) >= stall_pct);
      if (out_ready) begin
        void'(sb_q.pop_front());
        got++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_data  = out_data;
      end
    end
    checks++;
    if (got != max_out) begin
      failures++;
      $display("FAIL drain_timeout: got %0d outputs required %0d", got, max_out);
    end
  endtask

  // One cycle after the last output handshake the block must be back in FILL.
  task automatic check_refill;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if ({in_ready, out_valid, mat_valid} !== 3'b100) begin
      failures++;
      $display("FAIL refill: got ready/valid/mat=%b required 100", {in_ready, out_valid, mat_valid});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = 8'h00;
    flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, mat_valid, out_data, b_flat} !== 60'd0) begin
      failures++;
      $display("FAIL reset_values: got %0h required 0", {in_ready, out_valid, out_last, mat_valid, out_data, b_flat});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_early: got %b required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if ({in_ready, in_ready_a, in_ready_b} !== 3'b111) begin
      failures++;
      $display("FAIL reset_ready: got %b required 111", {in_ready, in_ready_a, in_ready_b});
    end
  endtask

  task automatic test_basic;
    fill_main(8'd1, 0);
    checks++;
    if (b_flat !== 48'h010402050306) begin
      failures++;
      $display("FAIL basic_b_flat: got %0h required 010402050306", b_flat);
    end
    drain_main(0, 6);
    check_refill();
  endtask

  task automatic test_stalls;
    fill_main(8'd1, 40);
    drain_main(40, 6);
    check_refill();
  endtask

  task automatic test_back_to_back;
    fill_main(8'd1, 0);
    drain_main(0, 6);
    check_refill();
    fill_main(8'd11, 0);
    checks++;
    if (b_flat !== 48'h0b0e0c0f0d10) begin
      failures++;
      $display("FAIL b2b_b_flat: got %0h required 0b0e0c0f0d10", b_flat);
    end
    drain_main(0, 6);
    check_refill();
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(99 + i);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL flush_pre_ready: got %b required 1", in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({in_ready, out_valid, mat_valid} !== 3'b100) begin
      failures++;
      $display("FAIL flush_fill: got ready/valid/mat=%b required 100", {in_ready, out_valid, mat_valid});
    end
    fill_main(8'd21, 0);
    drain_main(0, 6);
    check_refill();
    fill_main(8'd31, 0);
    drain_main(0, 2);
    @(negedge clk);
    flush     = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_last, mat_valid} !== 4'b1000) begin
      failures++;
      $display("FAIL flush_drain: got ready/valid/last/mat=%b required 1000",
               {in_ready, out_valid, out_last, mat_valid});
    end
    sb_q.delete();
    fill_main(8'd41, 0);
    drain_main(0, 6);
    check_refill();
  endtask

  task automatic test_async_reset;
    fill_main(8'd1, 0);
    drain_main(0, 2);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_last, mat_valid, out_data, b_flat} !== 60'd0) begin
      failures++;
      $display("FAIL async_reset: got %0h required 0", {in_ready, out_valid, out_last, mat_valid, out_data, b_flat});
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_degenerate;
    int cyc = 0;
    // 1x1
    @(negedge clk);
    checks++;
    if (in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL one_ready: got %b required 1", in_ready_a);
    end
    in_valid_a = 1'b1;
    in_data_a  = 8'hA5;
    @(negedge clk);
    in_valid_a = 1'b0;
    checks++;
    if ({out_valid_a, out_last_a, in_ready_a, out_data_a, b_flat_a} !== {3'b110, 8'hA5, 8'hA5}) begin
      failures++;
      $display("FAIL one_out: got valid/last/ready=%b data=%0h flat=%0h required 110 a5 a5",
               {out_valid_a, out_last_a, in_ready_a}, out_data_a, b_flat_a);
    end
    out_ready_a = 1'b1;
    @(negedge clk);
    out_ready_a = 1'b0;
    checks++;
    if ({out_valid_a, in_ready_a} !== 2'b01) begin
      failures++;
      $display("FAIL one_done: got valid/ready=%b required 01", {out_valid_a, in_ready_a});
    end
    // 3x1
    for (int i = 0; i < 3; i++) sb_b.push_back({(i == 2) ? 1'b1 : 1'b0, 8'(7 + i)});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid_b = 1'b1;
      in_data_b  = 8'(7 + i);
    end
    while (sb_b.size() > 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      in_valid_b = 1'b0;
      if (cyc == 1) begin
        checks++;
        if (b_flat_b !== 24'h070809) begin
          failures++;
          $display("FAIL col_b_flat: got %0h required 070809", b_flat_b);
        end
      end
      if (out_valid_b) begin
        checks++;
        if ({out_last_b, out_data_b} !== sb_b[0]) begin
          failures++;
          $display("FAIL col_data: got last=%b data=%0h required last=%b data=%0h",
                   out_last_b, out_data_b, sb_b[0][8], sb_b[0][7:0]);
        end
        void'(sb_b.pop_front());
        out_ready_b = 1'b1;
      end else begin
        out_ready_b = 1'b0;
      end
    end
    checks++;
    if (sb_b.size() != 0) begin
      failures++;
      $display("FAIL col_timeout: %0d outputs missing required 0", sb_b.size());
    end
    @(negedge clk);
    out_ready_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_degenerate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
